// File: rtl/swervolf_board_io.sv
// Board I/O conditioner: synchronised, optionally debounced switch inputs with edge/irq
// reporting, plus retimed LED outputs. Define BOARD_IO_DEBOUNCE_EN to enable debouncing.
module swervolf_board_io #(
  parameter int N_IN        = 16,
  parameter int N_OUT       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int OUT_STAGES  = 2,
  parameter int TICK_DIV    = 25000,
  parameter int DB_TICKS    = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_IN-1:0]  i_sw,
  output logic [N_IN-1:0]  o_sw,
  output logic [N_IN-1:0]  o_rise,
  output logic [N_IN-1:0]  o_fall,
  input  logic [N_IN-1:0]  i_irq_mask,
  input  logic [N_IN-1:0]  i_irq_clr,
  output logic [N_IN-1:0]  o_pending,
  output logic             o_irq,
  input  logic [N_OUT-1:0] i_led,
  output logic [N_OUT-1:0] o_led
);

  // Configuration sanity checks, evaluated at elaboration only.
  if (N_IN < 1 || N_IN > 32 || N_OUT < 1 || N_OUT > 32) begin : g_bad_width
    $error("swervolf_board_io: N_IN/N_OUT out of range 1..32");
  end
  if (SYNC_STAGES < 2 || OUT_STAGES < 1 || TICK_DIV < 1 || DB_TICKS < 1) begin : g_bad_depth
    $error("swervolf_board_io: stage/tick parameters out of range");
  end

  logic [N_IN-1:0]  r_sync [SYNC_STAGES];
  logic [N_IN-1:0]  w_s;
  logic [N_IN-1:0]  w_stable_next;
  logic [N_IN-1:0]  r_stable;
  logic [N_IN-1:0]  r_rise;
  logic [N_IN-1:0]  r_fall;
  logic [N_IN-1:0]  r_pending;
  logic             r_irq;
  logic [N_OUT-1:0] r_led [OUT_STAGES];

  // NOTE: these arrays are plain flop chains, not RAM, so every entry is reset explicitly.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= i_sw;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef BOARD_IO_DEBOUNCE_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(DB_TICKS + 1);

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic [CW-1:0] r_cnt      [N_IN];
  logic [CW-1:0] w_cnt_next [N_IN];

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
      for (int k = 0; k < N_IN; k++) r_cnt[k] <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      r_cnt   <= w_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_stable_next = r_stable;
    for (int k = 0; k < N_IN; k++) begin
      w_cnt_next[k] = r_cnt[k];
      if (w_s[k] == r_stable[k]) begin
        w_cnt_next[k] = '0;
      end else if (w_tick) begin
        if (r_cnt[k] + CW'(1) == CW'(DB_TICKS)) begin
          w_stable_next[k] = w_s[k];
          w_cnt_next[k]    = '0;
        end else begin
          w_cnt_next[k] = r_cnt[k] + CW'(1);
        end
      end
    end
  end
`else
  assign w_stable_next = w_s;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stable  <= '0;
      r_rise    <= '0;
      r_fall    <= '0;
      r_pending <= '0;
      r_irq     <= 1'b0;
    end else begin
      r_stable  <= w_stable_next;
      r_rise    <= w_stable_next & ~r_stable;
      r_fall    <= ~w_stable_next & r_stable;
      // A set in the same cycle as a clear wins.
      r_pending <= (r_pending & ~i_irq_clr) | r_rise | r_fall;
      r_irq     <= |(r_pending & i_irq_mask);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < OUT_STAGES; k++) r_led[k] <= '0;
    end else begin
      r_led[0] <= i_led;
      for (int k = 1; k < OUT_STAGES; k++) r_led[k] <= r_led[k-1];
    end
  end

  assign o_sw      = r_stable;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;
  assign o_pending = r_pending;
  assign o_irq     = r_irq;
  assign o_led     = r_led[OUT_STAGES-1];

endmodule

// File: tb/tb_swervolf_board_io.sv
// Directed bench for swervolf_board_io with an LED-pipeline scoreboard; expectations follow
// BOARD_IO_DEBOUNCE_EN so the same bench covers both builds.
module tb_swervolf_board_io;

  localparam int N_IN = 4, N_OUT = 4, SYNC_STAGES = 2, OUT_STAGES = 2;
  localparam int TICK_DIV = 4, DB_TICKS = 3;

`ifdef BOARD_IO_DEBOUNCE_EN
  localparam int LAT_MIN = SYNC_STAGES + (DB_TICKS - 1) * TICK_DIV + 1;
  localparam int LAT_MAX = SYNC_STAGES + (DB_TICKS - 1) * TICK_DIV + TICK_DIV;
  localparam int GL_HI = 0, GL_RISE = 0, GL_FALL = 0, GL_PEND = 0;
`else
  localparam int LAT_MIN = SYNC_STAGES + 1;
  localparam int LAT_MAX = SYNC_STAGES + 1;
  localparam int GL_HI = 3, GL_RISE = 1, GL_FALL = 1, GL_PEND = 1;
`endif

  logic             clk;
  logic             rstn;
  logic [N_IN-1:0]  i_sw, o_sw, o_rise, o_fall, i_irq_mask, i_irq_clr, o_pending;
  logic             o_irq;
  logic [N_OUT-1:0] i_led, o_led;

  logic [N_OUT-1:0] led_q [$];
  int errors = 0;
  int checks = 0;
  int lat, n, hi, nr, nf;

  swervolf_board_io #(
    .N_IN(N_IN), .N_OUT(N_OUT), .SYNC_STAGES(SYNC_STAGES), .OUT_STAGES(OUT_STAGES),
    .TICK_DIV(TICK_DIV), .DB_TICKS(DB_TICKS)
  ) dut (
    .clk(clk), .rstn(rstn), .i_sw(i_sw), .o_sw(o_sw), .o_rise(o_rise), .o_fall(o_fall),
    .i_irq_mask(i_irq_mask), .i_irq_clr(i_irq_clr), .o_pending(o_pending), .o_irq(o_irq),
    .i_led(i_led), .o_led(o_led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lat(input string tag, input int l);
    checks++;
    assert (l >= LAT_MIN && l <= LAT_MAX) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, l, LAT_MIN, LAT_MAX);
    end
  endtask

  // One clock step; the LED scoreboard expects each driven value OUT_STAGES edges later.
  task automatic tick();
    led_q.push_back(i_led);
    @(posedge clk);
    #1;
    check("led_sb", o_led, led_q.pop_front());
  endtask

  task automatic led_q_init();
    led_q.delete();
    for (int k = 0; k < OUT_STAGES - 1; k++) led_q.push_back('0);
  endtask

  task automatic wait_sw(input int ch, input logic val, output int l);
    l = 0;
    while (o_sw[ch] !== val && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sw"},   o_sw, 0);
    check({tag, "_rise"}, o_rise, 0);
    check({tag, "_fall"}, o_fall, 0);
    check({tag, "_pend"}, o_pending, 0);
    check({tag, "_irq"},  o_irq, 0);
    check({tag, "_led"},  o_led, 0);
  endtask

  initial begin
    rstn = 1'b0; i_sw = '0; i_led = '0; i_irq_mask = '0; i_irq_clr = '0;
    #2;
    check_all_zero("rst_init");
    #21;
    led_q_init();
    rstn = 1'b1;

    // Drive everything active, then reset mid-run.
    i_sw = 4'hF; i_led = 4'hA; i_irq_mask = 4'hF;
    repeat (30) tick();
    check("pre_rst_sw", o_sw, 4'hF);
    check("pre_rst_pend", o_pending, 4'hF);
    check("pre_rst_irq", o_irq, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check_all_zero("rst_async");
    i_sw = '0; i_led = '0; i_irq_mask = '0;
    repeat (2) @(posedge clk);
    #2;
    led_q_init();
    rstn = 1'b1;

    // Held step on channel 0.
    i_sw[0] = 1'b1;
    wait_sw(0, 1'b1, lat);
    check_lat("sw0_latency", lat);
    check("sw0_rise", o_rise, 4'b0001);
    check("sw0_fall", o_fall, 4'b0000);
    tick();
    check("sw0_rise_width", o_rise[0], 1'b0);
    check("sw0_pend", o_pending, 4'b0001);
    i_irq_clr = 4'b0001;
    tick();
    i_irq_clr = '0;
    check("sw0_pend_clr", o_pending, 4'b0000);

    // Three-cycle glitch on channel 1.
    hi = 0; nr = 0; nf = 0;
    i_sw[1] = 1'b1;
    for (int c = 0; c < 23; c++) begin
      if (c == 3) i_sw[1] = 1'b0;
      tick();
      hi += int'(o_sw[1]);
      nr += int'(o_rise[1]);
      nf += int'(o_fall[1]);
    end
    check("gl_hi_cycles", hi, GL_HI);
    check("gl_rise", nr, GL_RISE);
    check("gl_fall", nf, GL_FALL);
    check("gl_pend", o_pending[1], GL_PEND);
    i_irq_clr = 4'b0010;
    tick();
    i_irq_clr = '0;
    check("gl_pend_clr", o_pending, 4'b0000);

    // Masked edge on channel 2, then unmask and clear.
    i_sw[2] = 1'b1;
    wait_sw(2, 1'b1, lat);
    check_lat("sw2_latency", lat);
    tick();
    check("m_pend", o_pending, 4'b0100);
    check("m_irq_masked", o_irq, 1'b0);
    repeat (2) tick();
    check("m_irq_still_masked", o_irq, 1'b0);
    i_irq_mask = 4'b0100;
    tick();
    check("m_irq_unmasked", o_irq, 1'b1);
    i_irq_clr = 4'b0100;
    tick();
    i_irq_clr = '0;
    check("m_pend_clr", o_pending, 4'b0000);
    check("m_irq_lag", o_irq, 1'b1);
    tick();
    check("m_irq_drop", o_irq, 1'b0);

    // Clear coincident with a new fall edge on channel 3.
    i_sw[3] = 1'b1;
    wait_sw(3, 1'b1, lat);
    check_lat("sw3_latency", lat);
    tick();
    check("c_pend_set", o_pending[3], 1'b1);
    i_sw[3] = 1'b0;
    n = 0;
    while (o_fall[3] !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check_lat("sw3_fall_latency", n);
    check("c_fall_sw", o_sw[3], 1'b0);
    i_irq_clr = 4'b1000;
    tick();
    i_irq_clr = '0;
    check("c_set_wins", o_pending[3], 1'b1);
    i_irq_clr = 4'b1000;
    tick();
    i_irq_clr = '0;
    check("c_pend_clr", o_pending[3], 1'b0);

    // LED pipeline latency.
    i_led = 4'h5;
    tick();
    i_led = 4'hA;
    tick();
    check("led_5_at_2", o_led, 4'h5);
    tick();
    check("led_a_at_3", o_led, 4'hA);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
